mem_arbiter: RTL

- Two-requester arbiter/sequencer that shares the single data memory block (address, Writedata, memread, memwrite, readdata) between the instruction-fetch port (I, read-only) and the load/store port (D, read/write).
- Sits between the CPU controller and the memory.
- Grants one access at a time, drives the memory control strobes for a configurable occupancy, returns read data, and acknowledges with a one-cycle pulse.

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data memory between an instruction-fetch port (I,
// read-only) and a load/store port (D). One access at a time. Each access
// keeps the memory busy for MEM_LAT cycles, then the owning port gets its
// read data and a one-cycle ack. When both ports request in the same IDLE
// cycle, the port that was not granted last wins. All outputs are registered.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   i_req, i_addr                 fetch request / address (held until i_ack)
//   i_rdata, i_ack                fetched word, completion pulse
//   d_req, d_we, d_addr, d_wdata  load/store request (held until d_ack)
//   d_rdata, d_ack                load result, completion pulse
//   mem_address, mem_writedata    memory address / write data
//   mem_read, mem_write           memory strobes
//   mem_readdata                  memory read data (valid while mem_read)
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);
  localparam logic       PORT_I   = 1'b0;
  localparam logic       PORT_D   = 1'b1;
  localparam logic       LAT_ONE  = (MEM_LAT == 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic                store_q, store_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                grant_c;
  logic                store_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= 4'd0;
      owner_q         <= PORT_I;
      last_grant_q    <= PORT_I;
      store_q         <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      i_rdata_q       <= '0;
      d_rdata_q       <= '0;
      i_ack_q         <= 1'b0;
      d_ack_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      store_q         <= store_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      i_rdata_q       <= i_rdata_d;
      d_rdata_q       <= d_rdata_d;
      i_ack_q         <= i_ack_d;
      d_ack_q         <= d_ack_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    store_d         = store_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    i_rdata_d       = i_rdata_q;
    d_rdata_d       = d_rdata_q;
    i_ack_d         = 1'b0;
    d_ack_d         = 1'b0;
    grant_c         = PORT_I;
    store_c         = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the port that did not win last time gets the memory.
          grant_c         = (i_req && d_req) ? ~last_grant_q : d_req;
          store_c         = (grant_c == PORT_D) && d_we;
          owner_d         = grant_c;
          last_grant_d    = grant_c;
          store_d         = store_c;
          cnt_d           = CNT_INIT;
          mem_address_d   = (grant_c == PORT_D) ? d_addr : i_addr;
          if (store_c) begin
            mem_writedata_d = d_wdata;
          end
          mem_read_d      = ~store_c;
          // With a one-cycle occupancy the first BUSY cycle is also the last,
          // so the write strobe has to be raised at grant time.
          mem_write_d     = store_c && LAT_ONE;
          state_d         = BUSY;
        end
      end

      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          // Registered strobe: raise it one cycle early so it lands exactly
          // in the final BUSY cycle (cnt == 0).
          if (store_q && (cnt_q == 4'd1)) begin
            mem_write_d = 1'b1;
          end
        end else begin
          if (!store_q) begin
            if (owner_q == PORT_D) begin
              d_rdata_d = mem_readdata;
            end else begin
              i_rdata_d = mem_readdata;
            end
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (owner_q == PORT_D) begin
            d_ack_d = 1'b1;
          end else begin
            i_ack_d = 1'b1;
          end
          state_d = ACK;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign i_rdata       = i_rdata_q;
  assign i_ack         = i_ack_q;
  assign d_rdata       = d_rdata_q;
  assign d_ack         = d_ack_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;

endmodule
